// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module  : if_stage_pkg
// Brief   : Shared bus widths, constants and FSM encoding for the fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_DATA_W = 32;
    localparam int STALL_W     = 6;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_DATA_W-1:0] inst_data_t;
    typedef logic [STALL_W-1:0]     stall_t;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic        RST_ENABLE   = 1'b0;
    localparam logic        RST_DISABLE  = 1'b1;
    localparam logic        STOP         = 1'b1;
    localparam logic        NO_STOP      = 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/if_stage_if_id.sv
// ============================================================================
// Module  : if_stage_if_id
// Brief   : IF/ID pipeline register with flush, bubble and hold handling.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_if_id
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ce,
    input  logic       i_stall_if,
    input  logic       i_stall_id,
    input  logic       i_flush,
    input  inst_addr_t i_if_pc,
    input  inst_data_t i_if_inst,
    output inst_addr_t o_id_pc,
    output inst_data_t o_id_inst,
    output logic       o_id_fetch_exc
);

    inst_addr_t r_id_pc;
    inst_data_t r_id_inst;
    logic       r_id_fetch_exc;
    logic       w_misaligned;

    assign w_misaligned = (i_if_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_id_pc        <= ZERO_WORD;
            r_id_inst      <= ZERO_WORD;
            r_id_fetch_exc <= 1'b0;
        end else if (i_flush) begin
            r_id_pc        <= ZERO_WORD;
            r_id_inst      <= ZERO_WORD;
            r_id_fetch_exc <= 1'b0;
        end else if (i_stall_if == STOP && i_stall_id == NO_STOP) begin
            // IF stalled but ID advancing: hand ID a bubble.
            r_id_pc        <= ZERO_WORD;
            r_id_inst      <= ZERO_WORD;
            r_id_fetch_exc <= 1'b0;
        end else if (i_stall_if == NO_STOP) begin
            r_id_pc        <= i_if_pc;
            r_id_fetch_exc <= w_misaligned;
            r_id_inst      <= (w_misaligned || i_ce == CHIP_DISABLE) ? ZERO_WORD : i_if_inst;
        end
    end

    assign o_id_pc        = r_id_pc;
    assign o_id_inst      = r_id_inst;
    assign o_id_fetch_exc = r_id_fetch_exc;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Brief   : Instruction fetch: PC register, ROM enable FSM and IF/ID register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_fetch_exc
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic         r_ce;
    logic         w_ce_next;
    inst_addr_t   r_pc;
    inst_addr_t   w_pc_next;
    logic         w_unused_stall;

    assign w_unused_stall = ^stall[5:3];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= ST_IDLE;
            r_ce    <= CHIP_DISABLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_ce    <= w_ce_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ce_next    = r_ce;
        w_pc_next    = r_pc;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_RUN;
                w_ce_next    = CHIP_ENABLE;
            end
            ST_RUN: begin
                w_ce_next = CHIP_ENABLE;
                // Branch redirects only the next fetch; the delay slot at r_pc still issues.
                if (flush) begin
                    w_pc_next = new_pc;
                end else if (stall[0] == STOP) begin
                    w_pc_next = r_pc;
                end else if (branch_flag_i) begin
                    w_pc_next = branch_target_address_i;
                end else begin
                    w_pc_next = r_pc + 32'd4;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ce_next    = CHIP_DISABLE;
            end
        endcase
    end

    assign rom_ce   = r_ce;
    assign rom_addr = r_pc;

    if_stage_if_id u_if_id (
        .clk            (clk),
        .rst            (rst),
        .i_ce           (r_ce),
        .i_stall_if     (stall[1]),
        .i_stall_id     (stall[2]),
        .i_flush        (flush),
        .i_if_pc        (r_pc),
        .i_if_inst      (rom_inst),
        .o_id_pc        (id_pc),
        .o_id_inst      (id_inst),
        .o_id_fetch_exc (id_fetch_exc)
    );

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module  : tb_if_stage
// Brief   : Self-checking bench for if_stage with a reference model and scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_ROM_KEY  = 32'hA5A5_0000;

    typedef struct packed {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] idpc;
        logic [31:0] idinst;
        logic        exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = 6'b0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = 32'h0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_fetch_exc;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    // Reference model state
    logic        m_run, m_ce, m_exc;
    logic [31:0] m_pc, m_idpc, m_idinst;

    always #5 clk = ~clk;

    // ROM returns zero when disabled
    assign rom_inst = rom_ce ? (rom_addr ^ C_ROM_KEY) : 32'h0;

    if_stage #(.RESET_PC(C_RESET_PC)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .rom_ce                  (rom_ce),
        .rom_addr                (rom_addr),
        .rom_inst                (rom_inst),
        .id_pc                   (id_pc),
        .id_inst                 (id_inst),
        .id_fetch_exc            (id_fetch_exc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_next();
        logic [31:0] rinst;
        if (rst == 1'b0) begin
            m_run = 1'b0; m_ce = 1'b0; m_pc = C_RESET_PC;
            m_idpc = 32'h0; m_idinst = 32'h0; m_exc = 1'b0;
        end else begin
            rinst = m_ce ? (m_pc ^ C_ROM_KEY) : 32'h0;
            if (flush || (stall[1] && !stall[2])) begin
                m_idpc = 32'h0; m_idinst = 32'h0; m_exc = 1'b0;
            end else if (!stall[1]) begin
                m_idpc   = m_pc;
                m_exc    = (m_pc[1:0] != 2'b00);
                m_idinst = m_exc ? 32'h0 : rinst;
            end
            if (!m_run) begin
                m_run = 1'b1; m_ce = 1'b1;
            end else if (flush)         m_pc = new_pc;
            else if (stall[0])          m_pc = m_pc;
            else if (branch_flag_i)     m_pc = branch_target_address_i;
            else                        m_pc = m_pc + 32'd4;
        end
    endtask

    // Advance one clock: predict, push, then pop and compare after the edge.
    task automatic step();
        exp_t e;
        model_next();
        e = '{ce: m_ce, addr: m_pc, idpc: m_idpc, idinst: m_idinst, exc: m_exc};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_rom_ce",   {31'b0, rom_ce},       {31'b0, e.ce});
        check("sb_rom_addr", rom_addr,              e.addr);
        check("sb_id_pc",    id_pc,                 e.idpc);
        check("sb_id_inst",  id_inst,               e.idinst);
        check("sb_id_exc",   {31'b0, id_fetch_exc}, {31'b0, e.exc});
    endtask

    task automatic expect_now(input string tag, input logic ce, input logic [31:0] addr,
                              input logic [31:0] ipc, input logic [31:0] iinst, input logic exc);
        check({tag, "_ce"},   {31'b0, rom_ce},       {31'b0, ce});
        check({tag, "_addr"}, rom_addr,              addr);
        check({tag, "_idpc"}, id_pc,                 ipc);
        check({tag, "_inst"}, id_inst,               iinst);
        check({tag, "_exc"},  {31'b0, id_fetch_exc}, {31'b0, exc});
    endtask

    task automatic idle_inputs();
        stall = 6'b0; flush = 1'b0; new_pc = 32'h0;
        branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
    endtask

    initial begin
        m_run = 1'b0; m_ce = 1'b0; m_pc = C_RESET_PC;
        m_idpc = 32'h0; m_idinst = 32'h0; m_exc = 1'b0;

        // Reset and release
        rst = 1'b0;
        repeat (3) step();
        expect_now("reset", 1'b0, C_RESET_PC, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        expect_now("idle_exit", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        expect_now("fetch0", 1'b1, 32'h4, 32'h0, 32'hA5A5_0000, 1'b0);
        step();
        expect_now("fetch1", 1'b1, 32'h8, 32'h4, 32'hA5A5_0004, 1'b0);
        step();
        step();
        check("at_0x10", rom_addr, 32'h10);

        // Branch with delay slot
        branch_flag_i = 1'b1; branch_target_address_i = 32'h40;
        step();
        check("br_addr", rom_addr, 32'h40);
        check("br_delay_slot_pc", id_pc, 32'h10);
        idle_inputs();
        step();
        check("br_follow_addr", rom_addr, 32'h44);

        // Hold, then bubble
        stall = 6'b000111;
        repeat (2) step();
        expect_now("hold", 1'b1, 32'h44, 32'h40, 32'h40 ^ C_ROM_KEY, 1'b0);
        stall = 6'b000011;
        step();
        expect_now("bubble", 1'b1, 32'h44, 32'h0, 32'h0, 1'b0);
        idle_inputs();
        step();

        // Flush beats stall and branch
        flush = 1'b1; new_pc = 32'h20; stall = 6'b000001;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h80;
        step();
        expect_now("flush", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
        idle_inputs();

        // Misaligned branch target
        branch_flag_i = 1'b1; branch_target_address_i = 32'h42;
        step();
        idle_inputs();
        step();
        expect_now("misalign", 1'b1, 32'h46, 32'h42, 32'h0, 1'b1);

        // PC wrap
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        check("wrap_addr", rom_addr, 32'h0000_0000);
        check("wrap_idpc", id_pc, 32'hFFFF_FFFC);

        // Reset mid-run
        rst = 1'b0;
        step();
        expect_now("midrst", 1'b0, C_RESET_PC, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        check("midrst_idle_exit_ce", {31'b0, rom_ce}, 32'h1);
        check("midrst_idle_addr", rom_addr, C_RESET_PC);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       stall = 6'b000011;
                1:       stall = 6'b000111;
                2:       stall = 6'b001111;
                default: stall = 6'b000000;
            endcase
            branch_flag_i = ($urandom_range(0, 3) == 0);
            branch_target_address_i = $urandom & 32'hFFFF_FFFE;
            flush = ($urandom_range(0, 9) == 0);
            new_pc = $urandom;
            step();
        end
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
